// File: rtl/wb_stage_regfile_pkg.sv
// Shared constants for the write-back / register-file slice.
//   DATA_W_DEFAULT  default datapath width
//   NREG_DEFAULT    default number of architectural registers
//   CNT_W_DEFAULT   default retired-instruction counter width
//   REG_ZERO        hardwired-zero register number
//   LINK_REG        register written by jal
//   LINK_OFFSET     added to the jal PC to form the link value
package wb_stage_regfile_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int NREG_DEFAULT   = 32;
  localparam int CNT_W_DEFAULT  = 32;
  localparam int REG_AW         = 5;

  localparam logic [REG_AW-1:0] REG_ZERO    = 5'd0;
  localparam logic [REG_AW-1:0] LINK_REG    = 5'd31;
  localparam int                LINK_OFFSET = 4;

  // True when the register number names the hardwired-zero register.
  function automatic logic is_reg_zero(input logic [REG_AW-1:0] addr);
    return (addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_stage_regfile_if.sv
// Bundle of MEM/WB inputs, ID read ports, forwarding outputs and the
// retired-instruction counter for wb_stage_regfile.
//   master : pipeline side (drives MEM/WB fields and read addresses)
//   slave  : write-back stage (drives read data, forwarding, counter)
interface wb_stage_regfile_if
  import wb_stage_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int AW     = REG_AW,
  parameter int CNT_W  = CNT_W_DEFAULT
);

  logic              wb_valid;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic              wb_jal;
  logic              wb_jump;
  logic [DATA_W-1:0] wb_rd_data;
  logic [DATA_W-1:0] wb_result;
  logic [AW-1:0]     wb_wn;
  logic [DATA_W-1:0] wb_pc;
  logic [AW-1:0]     rs_addr;
  logic [AW-1:0]     rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              fwd_wen;
  logic [AW-1:0]     fwd_waddr;
  logic [DATA_W-1:0] fwd_wdata;
  logic [CNT_W-1:0]  retired_count;

  modport master (
    output wb_valid, wb_reg_write, wb_mem_to_reg, wb_jal, wb_jump,
    output wb_rd_data, wb_result, wb_wn, wb_pc, rs_addr, rt_addr,
    input  rs_data, rt_data, fwd_wen, fwd_waddr, fwd_wdata, retired_count
  );

  modport slave (
    input  wb_valid, wb_reg_write, wb_mem_to_reg, wb_jal, wb_jump,
    input  wb_rd_data, wb_result, wb_wn, wb_pc, rs_addr, rt_addr,
    output rs_data, rt_data, fwd_wen, fwd_waddr, fwd_wdata, retired_count
  );

endinterface

// File: rtl/wb_stage_regfile_regfile.sv
// regfile_2r1w: NREG x DATA_W architectural register file.
//   clk, rst          clock, synchronous active-high clear of all registers
//   we, waddr, wdata  single write port, committed on the rising edge
//   ra_addr/ra_data   read port A (combinational, write-first bypass)
//   rb_addr/rb_data   read port B (combinational, write-first bypass)
// Register 0 always reads zero and ignores writes.
module regfile_2r1w
  import wb_stage_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int NREG   = NREG_DEFAULT,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-first: an address being committed this cycle returns the
  // incoming value so ID sees the result without an extra stall.
  always_comb begin
    ra_data = regs[ra_addr];
    if (ra_addr == '0) begin
      ra_data = '0;
    end else if (we && (ra_addr == waddr)) begin
      ra_data = wdata;
    end
  end

  always_comb begin
    rb_data = regs[rb_addr];
    if (rb_addr == '0) begin
      rb_data = '0;
    end else if (we && (rb_addr == waddr)) begin
      rb_data = wdata;
    end
  end

endmodule

// File: rtl/wb_stage_regfile.sv
// wb_stage_regfile: write-back end of the MEM/WB boundary.
//   clk   clock, all state on the rising edge
//   rst   synchronous active-high reset (clears registers and counter,
//         discards the instruction currently in WB)
//   bus   wb_stage_regfile_if.slave: MEM/WB fields in, ID read ports,
//         EX forwarding copy of the committed write, retired counter
// Selects load data / ALU result / jal link value, commits it to the
// register file and counts every valid instruction leaving WB.
module wb_stage_regfile
  import wb_stage_regfile_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int NREG        = NREG_DEFAULT,
  parameter int LINK_REG    = int'(wb_stage_regfile_pkg::LINK_REG),
  parameter int LINK_OFFSET = wb_stage_regfile_pkg::LINK_OFFSET,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  wb_stage_regfile_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  logic [DATA_W-1:0] link_val;
  logic [DATA_W-1:0] wval;
  logic [AW-1:0]     waddr;
  logic              wen;
  logic [CNT_W-1:0]  cnt;

  // jal overrides both the data source and the destination.
  always_comb begin
    link_val = bus.wb_pc + DATA_W'(LINK_OFFSET);
    if (bus.wb_jal) begin
      wval  = link_val;
      waddr = AW'(LINK_REG);
    end else begin
      wval  = bus.wb_mem_to_reg ? bus.wb_rd_data : bus.wb_result;
      waddr = bus.wb_wn;
    end
  end

  // Writes to r0 never raise the enable, so forwarding never advertises
  // a value for r0. Reset squashes the WB instruction entirely.
  assign wen = ~rst & bus.wb_valid & (bus.wb_reg_write | bus.wb_jal)
             & (waddr != '0);

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wen),
    .waddr   (waddr),
    .wdata   (wval),
    .ra_addr (bus.rs_addr),
    .ra_data (bus.rs_data),
    .rb_addr (bus.rt_addr),
    .rb_data (bus.rt_data)
  );

  assign bus.fwd_wen   = wen;
  assign bus.fwd_waddr = wen ? waddr : '0;
  assign bus.fwd_wdata = wen ? wval  : '0;

  // Retired counter: every valid slot counts, wrapping silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.wb_valid) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.retired_count = cnt;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for wb_stage_regfile: main 32-bit build plus a CNT_W=4
// build used for the counter wrap scenario.
module tb_wb_stage_regfile;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  wb_stage_regfile_if #(.DATA_W(32), .AW(5), .CNT_W(32)) bus ();
  wb_stage_regfile_if #(.DATA_W(32), .AW(5), .CNT_W(4))  bus4 ();

  wb_stage_regfile #(.DATA_W(32), .NREG(32), .LINK_REG(31), .LINK_OFFSET(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  wb_stage_regfile #(.DATA_W(32), .NREG(32), .LINK_REG(31), .LINK_OFFSET(4), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid      = 1'b0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_mem_to_reg = 1'b0;
    bus.wb_jal        = 1'b0;
    bus.wb_jump       = 1'b0;
    bus.wb_rd_data    = '0;
    bus.wb_result     = '0;
    bus.wb_wn         = '0;
    bus.wb_pc         = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.rs_addr = 5'd5;
    bus.rt_addr = 5'd5;
    bus4.wb_valid = 1'b0; bus4.wb_reg_write = 1'b0; bus4.wb_mem_to_reg = 1'b0;
    bus4.wb_jal = 1'b0; bus4.wb_jump = 1'b0; bus4.wb_rd_data = '0;
    bus4.wb_result = '0; bus4.wb_wn = '0; bus4.wb_pc = '0;
    bus4.rs_addr = '0; bus4.rt_addr = '0;
    rst = 1'b1;
    bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_wn = 5'd5;
    bus.wb_result = 32'h5555_AAAA;
    tick();
    #1;
    n_checks++;
    if (bus.fwd_wen !== 1'b0) begin
      n_fail++; $display("FAIL reset_fwd_wen got=%0b exp=0", bus.fwd_wen);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if (bus.retired_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.retired_count);
    end
    n_checks++;
    if (bus.rs_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_r5 got=%h exp=0", bus.rs_data);
    end
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(31 - i);
      #1;
      n_checks++;
      if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
        n_fail++; $display("FAIL reset_reg%0d got=%h/%h exp=0", i, bus.rs_data, bus.rt_data);
      end
    end
  endtask

  task automatic test_alu_write();
    bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_mem_to_reg = 1'b0;
    bus.wb_result = 32'h1234_5678; bus.wb_rd_data = 32'h0BAD_0BAD; bus.wb_wn = 5'd8;
    bus.rs_addr = 5'd8; bus.rt_addr = 5'd8;
    #1;
    n_checks++;
    if (bus.rs_data !== 32'h1234_5678 || bus.rt_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL alu_bypass got=%h/%h exp=12345678", bus.rs_data, bus.rt_data);
    end
    n_checks++;
    if (bus.fwd_wen !== 1'b1 || bus.fwd_waddr !== 5'd8 || bus.fwd_wdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL alu_fwd got=%b/%0d/%h exp=1/8/12345678", bus.fwd_wen, bus.fwd_waddr, bus.fwd_wdata);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.rs_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL alu_stored got=%h exp=12345678", bus.rs_data);
    end
    n_checks++;
    if (bus.retired_count !== 32'd1) begin
      n_fail++; $display("FAIL alu_count got=%0d exp=1", bus.retired_count);
    end
  endtask

  task automatic test_load_write();
    bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_mem_to_reg = 1'b1;
    bus.wb_rd_data = 32'hDEAD_BEEF; bus.wb_result = 32'h0000_0001; bus.wb_wn = 5'd9;
    bus.rs_addr = 5'd8; bus.rt_addr = 5'd9;
    #1;
    n_checks++;
    if (bus.fwd_wdata !== 32'hDEAD_BEEF || bus.rt_data !== 32'hDEAD_BEEF || bus.rs_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL load_bypass got=%h/%h/%h exp=deadbeef/deadbeef/12345678", bus.fwd_wdata, bus.rt_data, bus.rs_data);
    end
    tick();
    idle_inputs();
    bus.rs_addr = 5'd9;
    #1;
    n_checks++;
    if (bus.rs_data !== 32'hDEAD_BEEF || bus.retired_count !== 32'd2) begin
      n_fail++; $display("FAIL load_stored got=%h cnt=%0d exp=deadbeef cnt=2", bus.rs_data, bus.retired_count);
    end
  endtask

  task automatic test_jal();
    bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b0; bus.wb_jal = 1'b1; bus.wb_jump = 1'b1;
    bus.wb_mem_to_reg = 1'b1; bus.wb_rd_data = 32'h7777_7777; bus.wb_pc = 32'h0000_0040; bus.wb_wn = 5'd3;
    bus.rs_addr = 5'd31; bus.rt_addr = 5'd3;
    #1;
    n_checks++;
    if (bus.fwd_wen !== 1'b1 || bus.fwd_waddr !== 5'd31 || bus.fwd_wdata !== 32'h0000_0044) begin
      n_fail++; $display("FAIL jal_fwd got=%b/%0d/%h exp=1/31/00000044", bus.fwd_wen, bus.fwd_waddr, bus.fwd_wdata);
    end
    tick();
    bus.wb_pc = 32'hFFFF_FFFC;
    #1;
    n_checks++;
    if (bus.fwd_wdata !== 32'h0000_0000 || bus.fwd_wen !== 1'b1 || bus.rs_data !== 32'h0000_0000) begin
      n_fail++; $display("FAIL jal_wrap_fwd got=%b/%h rs=%h exp=1/00000000 rs=0", bus.fwd_wen, bus.fwd_wdata, bus.rs_data);
    end
    idle_inputs();
    #1;
    n_checks++;
    if (bus.rs_data !== 32'h0000_0044 || bus.rt_data !== 32'h0 || bus.retired_count !== 32'd3) begin
      n_fail++; $display("FAIL jal_stored got r31=%h r3=%h cnt=%0d exp=44/0/3", bus.rs_data, bus.rt_data, bus.retired_count);
    end
    bus.wb_valid = 1'b1; bus.wb_jal = 1'b1; bus.wb_jump = 1'b1; bus.wb_pc = 32'hFFFF_FFFC; bus.wb_wn = 5'd3;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.rs_data !== 32'h0000_0000 || bus.rt_data !== 32'h0 || bus.retired_count !== 32'd4) begin
      n_fail++; $display("FAIL jal_wrap_stored got r31=%h r3=%h cnt=%0d exp=0/0/4", bus.rs_data, bus.rt_data, bus.retired_count);
    end
  endtask

  task automatic test_zero_bubble();
    bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_result = 32'hFFFF_FFFF; bus.wb_wn = 5'd0;
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
    #1;
    n_checks++;
    if (bus.fwd_wen !== 1'b0 || bus.fwd_waddr !== 5'd0 || bus.fwd_wdata !== 32'd0 || bus.rs_data !== 32'd0) begin
      n_fail++; $display("FAIL zero_write got=%b/%0d/%h rs=%h exp=0/0/0 rs=0", bus.fwd_wen, bus.fwd_waddr, bus.fwd_wdata, bus.rs_data);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.rt_data !== 32'd0 || bus.retired_count !== 32'd5) begin
      n_fail++; $display("FAIL zero_after got r0=%h cnt=%0d exp=0/5", bus.rt_data, bus.retired_count);
    end
    bus.wb_valid = 1'b0; bus.wb_reg_write = 1'b1; bus.wb_jal = 1'b1; bus.wb_wn = 5'd4;
    bus.wb_result = 32'hAAAA_5555; bus.rs_addr = 5'd4; bus.rt_addr = 5'd31;
    #1;
    n_checks++;
    if (bus.fwd_wen !== 1'b0 || bus.fwd_wdata !== 32'd0 || bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
      n_fail++; $display("FAIL bubble_comb got=%b/%h rs=%h rt=%h exp=0/0/0/0", bus.fwd_wen, bus.fwd_wdata, bus.rs_data, bus.rt_data);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.rs_data !== 32'd0 || bus.retired_count !== 32'd5) begin
      n_fail++; $display("FAIL bubble_after got r4=%h cnt=%0d exp=0/5", bus.rs_data, bus.retired_count);
    end
  endtask

  task automatic test_jump_no_link();
    bus.wb_valid = 1'b1; bus.wb_jump = 1'b1; bus.wb_reg_write = 1'b0; bus.wb_wn = 5'd6;
    bus.wb_result = 32'h6666_6666; bus.rs_addr = 5'd6;
    #1;
    n_checks++;
    if (bus.fwd_wen !== 1'b0 || bus.rs_data !== 32'd0) begin
      n_fail++; $display("FAIL jump_comb got=%b rs=%h exp=0/0", bus.fwd_wen, bus.rs_data);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.rs_data !== 32'd0 || bus.retired_count !== 32'd6) begin
      n_fail++; $display("FAIL jump_after got r6=%h cnt=%0d exp=0/6", bus.rs_data, bus.retired_count);
    end
  endtask

  task automatic test_back_to_back();
    bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_result = 32'h0000_0011; bus.wb_wn = 5'd10;
    tick();
    bus.wb_result = 32'h0000_0022; bus.wb_wn = 5'd11;
    bus.rs_addr = 5'd10; bus.rt_addr = 5'd11;
    #1;
    n_checks++;
    if (bus.rs_data !== 32'h11 || bus.rt_data !== 32'h22) begin
      n_fail++; $display("FAIL b2b_mid got=%h/%h exp=11/22", bus.rs_data, bus.rt_data);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.rs_data !== 32'h11 || bus.rt_data !== 32'h22 || bus.retired_count !== 32'd8) begin
      n_fail++; $display("FAIL b2b_after got=%h/%h cnt=%0d exp=11/22/8", bus.rs_data, bus.rt_data, bus.retired_count);
    end
  endtask

  task automatic test_mid_reset();
    bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_result = 32'h0000_0077; bus.wb_wn = 5'd12;
    bus.rs_addr = 5'd12; bus.rt_addr = 5'd8;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.fwd_wen !== 1'b0 || bus.rs_data !== 32'd0) begin
      n_fail++; $display("FAIL midrst_comb got=%b rs=%h exp=0/0", bus.fwd_wen, bus.rs_data);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0 || bus.retired_count !== 32'd0) begin
      n_fail++; $display("FAIL midrst_after got r12=%h r8=%h cnt=%0d exp=0/0/0", bus.rs_data, bus.rt_data, bus.retired_count);
    end
  endtask

  task automatic test_counter_wrap();
    n_checks++;
    if (bus4.retired_count !== 4'd0) begin
      n_fail++; $display("FAIL wrap_start got=%0d exp=0", bus4.retired_count);
    end
    bus4.wb_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        n_checks++;
        if (bus4.retired_count !== 4'd15) begin
          n_fail++; $display("FAIL wrap_max got=%0d exp=15", bus4.retired_count);
        end
      end
    end
    bus4.wb_valid = 1'b0;
    n_checks++;
    if (bus4.retired_count !== 4'd0) begin
      n_fail++; $display("FAIL wrap_zero got=%0d exp=0", bus4.retired_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    test_reset();
    test_alu_write();
    test_load_write();
    test_jal();
    test_zero_bubble();
    test_jump_no_link();
    test_back_to_back();
    test_mid_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
